// File: rtl/button_encoder_if.sv
// Pin-side bundle between the raw button lines and the controller input port.
// master: the encoder (samples BTN, drives the code handshake); slave: the consumer.
interface button_encoder_if;
  logic [3:0] BTN;
  logic [1:0] CODE;
  logic       CODE_VALID;
  logic       PRESS;

  modport master (
    input  BTN,
    output CODE,
    output CODE_VALID,
    output PRESS
  );

  modport slave (
    output BTN,
    input  CODE,
    input  CODE_VALID,
    input  PRESS
  );
endinterface

// File: rtl/button_encoder.sv
// Button front end: 2-flop sync, press/release debounce, colour encode with level valid.
// Optional macro BUTTON_ENCODER_MULTI_REJECT_EN: accept only one-hot presses.
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  button_encoder_if.master bus
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_DB   = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] RELEASE_DB = 2'd3;

  logic [3:0]       btn_p0;
  logic [3:0]       btn_s;
  logic [1:0]       state;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       code;
  logic             code_valid;
  logic             press;

  function automatic logic acceptable(input logic [3:0] p);
`ifdef BUTTON_ENCODER_MULTI_REJECT_EN
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
`else
    return (p != 4'd0);
`endif
  endfunction

  // Lowest set bit wins; for one-hot patterns this is simply the bit index.
  function automatic logic [1:0] encode(input logic [3:0] p);
    if (p[0])      return 2'd0;
    else if (p[1]) return 2'd1;
    else if (p[2]) return 2'd2;
    else if (p[3]) return 2'd3;
    else           return 2'd0;
  endfunction

  // Synchronizer: btn_p0 is the metastability stage, btn_s feeds every decision
  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_p0 <= '0;
      btn_s  <= '0;
    end else begin
      btn_p0 <= bus.BTN;
      btn_s  <= btn_p0;
    end
  end

  // Debounce FSM and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        IDLE: begin
          code_valid <= 1'b0;
          if (acceptable(btn_s)) begin
            cand  <= btn_s;
            cnt   <= '0;
            state <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (btn_s != cand) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt        <= '0;
            code       <= encode(cand);
            code_valid <= 1'b1;
            press      <= 1'b1;
            state      <= HELD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          code_valid <= 1'b1;
          if (btn_s != cand) begin
            cnt   <= '0;
            state <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          // Any other button still down restarts the release window
          if (btn_s == cand) begin
            cnt   <= '0;
            state <= HELD;
          end else if (btn_s != 4'd0) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt        <= '0;
            code_valid <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt        <= '0;
          code_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.CODE       = code;
  assign bus.CODE_VALID = code_valid;
  assign bus.PRESS      = press;

endmodule

// File: tb/tb_button_encoder.sv
// Directed bench for button_encoder (DEBOUNCE_CYCLES=4): expectations are queued
// against absolute edge numbers and compared by a negedge monitor.
module tb_button_encoder;

  localparam int DB = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  button_encoder_if bus();

  button_encoder #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      tag;
    logic       chk_code;
    logic [1:0] code;
    logic       valid;
    logic       press;
  } exp_t;

  exp_t sb[$];

  task automatic expect_at(input int c, input string tag, input logic chk_code,
                           input logic [1:0] code, input logic valid, input logic press);
    exp_t e;
    int   i;
    e.cyc = c; e.tag = tag; e.chk_code = chk_code;
    e.code = code; e.valid = valid; e.press = press;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic expect_range(input int a, input int b, input string tag, input logic chk_code,
                              input logic [1:0] code, input logic valid, input logic press);
    for (int c = a; c <= b; c++) expect_at(c, tag, chk_code, code, valid, press);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Edge index that will first sample a value driven now
  function automatic int next_edge();
    return cyc + 1;
  endfunction

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (e.cyc == cyc && (!e.chk_code || bus.CODE === e.code) &&
              bus.CODE_VALID === e.valid && bus.PRESS === e.press)
      else begin
        errors++;
        $error("FAIL %s edge=%0d(at %0d): observed code=%0d valid=%b press=%b, expected code=%0d valid=%b press=%b",
               e.tag, e.cyc, cyc, bus.CODE, bus.CODE_VALID, bus.PRESS, e.code, e.valid, e.press);
      end
    end
  end

  initial begin
    int e0;
    int r0;
    int k;
    bus.BTN = 4'd0;

    // Reset
    RST = 1'b1;
    tick(2);
    expect_at(cyc, "reset", 1'b1, 2'd0, 1'b0, 1'b0);
    RST = 1'b0;
    tick(2);

    // Clean press of colour 2 and release
    bus.BTN = 4'b0100;
    e0 = next_edge();
    expect_range(e0, e0 + DB + 1, "press2_wait", 1'b1, 2'd0, 1'b0, 1'b0);
    expect_at(e0 + DB + 2, "press2_rise", 1'b1, 2'd2, 1'b1, 1'b1);
    expect_range(e0 + DB + 3, e0 + 19, "press2_hold", 1'b1, 2'd2, 1'b1, 1'b0);
    tick(20);
    bus.BTN = 4'd0;
    r0 = next_edge();
    expect_range(r0, r0 + DB + 1, "rel2_wait", 1'b1, 2'd2, 1'b1, 1'b0);
    expect_range(r0 + DB + 2, r0 + DB + 4, "rel2_fall", 1'b1, 2'd2, 1'b0, 1'b0);
    tick(10);

    // Press bounce: never long enough to register
    e0 = next_edge();
    expect_range(e0, e0 + 18, "press_bounce", 1'b1, 2'd2, 1'b0, 1'b0);
    bus.BTN = 4'b0001; tick(3);
    bus.BTN = 4'b0000; tick(3);
    bus.BTN = 4'b0001; tick(3);
    bus.BTN = 4'b0000; tick(10);

    // Release bounce while holding colour 3
    bus.BTN = 4'b1000;
    e0 = next_edge();
    expect_at(e0 + DB + 2, "press3_rise", 1'b1, 2'd3, 1'b1, 1'b1);
    expect_at(e0 + DB + 3, "press3_pulse_end", 1'b1, 2'd3, 1'b1, 1'b0);
    tick(12);
    e0 = next_edge();
    expect_range(e0, e0 + 12, "rel_bounce", 1'b1, 2'd3, 1'b1, 1'b0);
    bus.BTN = 4'b0000; tick(2);
    bus.BTN = 4'b1000; tick(11);
    bus.BTN = 4'b0000;
    r0 = next_edge();
    expect_range(r0, r0 + DB + 1, "rel3_wait", 1'b1, 2'd3, 1'b1, 1'b0);
    expect_at(r0 + DB + 2, "rel3_fall", 1'b1, 2'd3, 1'b0, 1'b0);
    tick(10);

    // Two buttons at once
    bus.BTN = 4'b0101;
    e0 = next_edge();
`ifdef BUTTON_ENCODER_MULTI_REJECT_EN
    expect_range(e0, e0 + 19, "multi_reject", 1'b1, 2'd3, 1'b0, 1'b0);
    tick(20);
    bus.BTN = 4'd0;
    tick(10);
`else
    expect_range(e0, e0 + DB + 1, "multi_wait", 1'b1, 2'd3, 1'b0, 1'b0);
    expect_at(e0 + DB + 2, "multi_rise", 1'b1, 2'd0, 1'b1, 1'b1);
    expect_range(e0 + DB + 3, e0 + 19, "multi_hold", 1'b1, 2'd0, 1'b1, 1'b0);
    tick(20);
    bus.BTN = 4'd0;
    r0 = next_edge();
    expect_at(r0 + DB + 2, "multi_fall", 1'b1, 2'd0, 1'b0, 1'b0);
    tick(10);
`endif

    // Held on colour 1, add bit 3, drop bit 1: must wait for all-released
    bus.BTN = 4'b0010;
    e0 = next_edge();
    expect_at(e0 + DB + 2, "press1_rise", 1'b1, 2'd1, 1'b1, 1'b1);
    tick(12);
    e0 = next_edge();
    expect_range(e0, e0 + 12, "overlap_hold", 1'b1, 2'd1, 1'b1, 1'b0);
    bus.BTN = 4'b1010; tick(5);
    bus.BTN = 4'b1000; tick(8);
    bus.BTN = 4'b0000;
    r0 = next_edge();
    expect_range(r0, r0 + DB, "overlap_rel_wait", 1'b1, 2'd1, 1'b1, 1'b0);
    expect_range(r0 + DB + 2, r0 + DB + 4, "overlap_fall", 1'b1, 2'd1, 1'b0, 1'b0);
    tick(10);

    // Reset while HELD with the button still down
    bus.BTN = 4'b0010;
    e0 = next_edge();
    expect_at(e0 + DB + 2, "pre_reset_held", 1'b1, 2'd1, 1'b1, 1'b1);
    tick(10);
    RST = 1'b1;
    tick(1);
    k = cyc;
    expect_range(k, k + DB + 2, "reset_mid", 1'b1, 2'd0, 1'b0, 1'b0);
    RST = 1'b0;
    expect_at(k + 1 + DB + 2, "rereg_rise", 1'b1, 2'd1, 1'b1, 1'b1);
    expect_at(k + 1 + DB + 3, "rereg_pulse_end", 1'b1, 2'd1, 1'b1, 1'b0);
    tick(12);
    bus.BTN = 4'd0;
    tick(10);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 200 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $error("FAIL drain: observed %0d pending expectations, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
